// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: the decoded ID instruction, the MEM/WB writeback taps used
// for forwarding, and the operands/controls the stage presents to EX.
// master = the side driving the ID/MEM/WB information, slave = id_ex_stage.
interface id_ex_stage_if;
    // ID-stage instruction
    logic        iValid;
    logic        iFlush;
    logic [31:0] iRsData;
    logic [31:0] iRtData;
    logic [4:0]  iRs;
    logic [4:0]  iRt;
    logic [4:0]  iRd;
    logic [31:0] iImm;
    logic [4:0]  iShamt;
    logic [5:0]  iALUFun;
    logic        iSign;
    logic        iALUSrc;
    logic        iShiftSrc;
    logic        iRegWr;
    logic        iMemRd;
    // MEM / WB writeback taps
    logic        iMemRegWr;
    logic [4:0]  iMemWAddr;
    logic [31:0] iMemResult;
    logic        iWbRegWr;
    logic [4:0]  iWbWAddr;
    logic [31:0] iWbResult;
    // EX-side results
    logic [31:0] oA;
    logic [31:0] oB;
    logic [5:0]  oALUFun;
    logic        oSign;
    logic [4:0]  oRd;
    logic        oRegWr;
    logic        oMemRd;
    logic        oValid;
    logic [31:0] oStoreData;
    logic        oStallID;

    modport master (
        output iValid, iFlush, iRsData, iRtData, iRs, iRt, iRd, iImm, iShamt,
               iALUFun, iSign, iALUSrc, iShiftSrc, iRegWr, iMemRd,
               iMemRegWr, iMemWAddr, iMemResult, iWbRegWr, iWbWAddr, iWbResult,
        input  oA, oB, oALUFun, oSign, oRd, oRegWr, oMemRd, oValid, oStoreData, oStallID
    );

    modport slave (
        input  iValid, iFlush, iRsData, iRtData, iRs, iRt, iRd, iImm, iShamt,
               iALUFun, iSign, iALUSrc, iShiftSrc, iRegWr, iMemRd,
               iMemRegWr, iMemWAddr, iMemResult, iWbRegWr, iWbWAddr, iWbResult,
        output oA, oB, oALUFun, oSign, oRd, oRegWr, oMemRd, oValid, oStoreData, oStallID
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and operand forwarding.
// Configuration macro FORWARD_EN:
//   defined   -> MEM/WB forwarding into the EX operands; only load-use stalls.
//   undefined -> no forwarding; ID stalls on any RAW match against EX or MEM
//                and waits for the WB write-through at capture.
// Register 0 is never forwarded, written through, or stalled on.
module id_ex_stage (
    input  logic         iClk,
    input  logic         iReset,
    id_ex_stage_if.slave bus
);

`ifdef FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    // EX-stage state
    logic        valid_r;
    logic        regWr_r;
    logic        memRd_r;
    logic        sign_r;
    logic        aluSrc_r;
    logic        shiftSrc_r;
    logic [4:0]  rd_r;
    logic [4:0]  rs_r;
    logic [4:0]  rt_r;
    logic [4:0]  shamt_r;
    logic [5:0]  aluFun_r;
    logic [31:0] rsData_r;
    logic [31:0] rtData_r;
    logic [31:0] imm_r;

    logic        loadUse_s;
    logic        rawEx_s;
    logic        rawMem_s;
    logic        stall_s;
    logic        bubble_s;
    logic [31:0] rsCap_s;
    logic [31:0] rtCap_s;
    logic [31:0] rsFwd_s;
    logic [31:0] rtFwd_s;

    // A writer targets src when it is enabled and the address is a real register.
    function automatic logic regMatch(input logic wrEn, input logic [4:0] wAddr,
                                      input logic [4:0] src);
        return wrEn && (wAddr != 5'd0) && (wAddr == src);
    endfunction

    // Hazard detection: load-use always, plain RAW on EX/MEM only without forwarding.
    always_comb begin
        loadUse_s = valid_r && memRd_r && (rd_r != 5'd0)
                    && ((rd_r == bus.iRs) || (rd_r == bus.iRt));
        rawEx_s   = regMatch(valid_r && regWr_r, rd_r, bus.iRs)
                    || regMatch(valid_r && regWr_r, rd_r, bus.iRt);
        rawMem_s  = regMatch(bus.iMemRegWr, bus.iMemWAddr, bus.iRs)
                    || regMatch(bus.iMemRegWr, bus.iMemWAddr, bus.iRt);
        if (bus.iFlush) begin
            stall_s = 1'b0;
        end else if (!bus.iValid) begin
            stall_s = 1'b0;
        end else if (FWD_ON) begin
            stall_s = loadUse_s;
        end else begin
            stall_s = loadUse_s || rawEx_s || rawMem_s;
        end
    end

    // Decide whether this edge loads a bubble instead of the ID instruction.
    always_comb begin
        if (bus.iFlush) begin
            bubble_s = 1'b1;
        end else if (stall_s) begin
            bubble_s = 1'b1;
        end else if (!bus.iValid) begin
            bubble_s = 1'b1;
        end else begin
            bubble_s = 1'b0;
        end
    end

    // WB write-through: a register being written this cycle is read as its new value.
    always_comb begin
        if (regMatch(bus.iWbRegWr, bus.iWbWAddr, bus.iRs)) begin
            rsCap_s = bus.iWbResult;
        end else begin
            rsCap_s = bus.iRsData;
        end
        if (regMatch(bus.iWbRegWr, bus.iWbWAddr, bus.iRt)) begin
            rtCap_s = bus.iWbResult;
        end else begin
            rtCap_s = bus.iRtData;
        end
    end

    // Operand forwarding on the registered sources; MEM is newer so it beats WB.
    always_comb begin
        if (FWD_ON && regMatch(bus.iMemRegWr, bus.iMemWAddr, rs_r)) begin
            rsFwd_s = bus.iMemResult;
        end else if (FWD_ON && regMatch(bus.iWbRegWr, bus.iWbWAddr, rs_r)) begin
            rsFwd_s = bus.iWbResult;
        end else begin
            rsFwd_s = rsData_r;
        end
        if (FWD_ON && regMatch(bus.iMemRegWr, bus.iMemWAddr, rt_r)) begin
            rtFwd_s = bus.iMemResult;
        end else if (FWD_ON && regMatch(bus.iWbRegWr, bus.iWbWAddr, rt_r)) begin
            rtFwd_s = bus.iWbResult;
        end else begin
            rtFwd_s = rtData_r;
        end
    end

    // ID->EX capture: reset clears everything, a bubble clears only the controls.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            valid_r    <= 1'b0;
            regWr_r    <= 1'b0;
            memRd_r    <= 1'b0;
            sign_r     <= 1'b0;
            aluSrc_r   <= 1'b0;
            shiftSrc_r <= 1'b0;
            rd_r       <= 5'd0;
            rs_r       <= 5'd0;
            rt_r       <= 5'd0;
            shamt_r    <= 5'd0;
            aluFun_r   <= 6'd0;
            rsData_r   <= 32'd0;
            rtData_r   <= 32'd0;
            imm_r      <= 32'd0;
        end else begin
            valid_r    <= !bubble_s;
            regWr_r    <= bus.iRegWr && !bubble_s;
            memRd_r    <= bus.iMemRd && !bubble_s;
            sign_r     <= bus.iSign;
            aluSrc_r   <= bus.iALUSrc;
            shiftSrc_r <= bus.iShiftSrc;
            rd_r       <= bus.iRd;
            rs_r       <= bus.iRs;
            rt_r       <= bus.iRt;
            shamt_r    <= bus.iShamt;
            aluFun_r   <= bus.iALUFun;
            rsData_r   <= rsCap_s;
            rtData_r   <= rtCap_s;
            imm_r      <= bus.iImm;
        end
    end

    assign bus.oA         = shiftSrc_r ? {27'd0, shamt_r} : rsFwd_s;
    assign bus.oB         = aluSrc_r ? imm_r : rtFwd_s;
    assign bus.oStoreData = rtFwd_s;
    assign bus.oALUFun    = aluFun_r;
    assign bus.oSign      = sign_r;
    assign bus.oRd        = rd_r;
    assign bus.oRegWr     = regWr_r;
    assign bus.oMemRd     = memRd_r;
    assign bus.oValid     = valid_r;
    assign bus.oStallID   = stall_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a stimulus process drives ID/MEM/WB
// inputs and pushes the reference model's expectations into a scoreboard; a
// monitor process pops and compares on every falling clock edge.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    id_ex_stage_if bus ();

    id_ex_stage dut (.iClk(clk), .iReset(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        reset, valid, flush;
        logic [31:0] rsData, rtData;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [5:0]  fun;
        logic        sign, aluSrc, shiftSrc, regWr, memRd;
        logic        memRegWr;
        logic [4:0]  memWAddr;
        logic [31:0] memResult;
        logic        wbRegWr;
        logic [4:0]  wbWAddr;
        logic [31:0] wbResult;
    } stim_t;

    // The instruction currently sitting in EX, as the architecture sees it.
    typedef struct {
        bit          present, writes, loads, cleared;
        logic [4:0]  rd, rs, rt, shamt;
        logic [5:0]  fun;
        logic        sign, useImm, useShamt;
        logic [31:0] rsVal, rtVal, imm;
    } ex_t;

    typedef struct {
        int          cyc;
        logic        valid, regWr, memRd, stall, care;
        logic [4:0]  rd;
        logic [5:0]  fun;
        logic        sign;
        logic [31:0] a, b, store;
    } exp_t;

    exp_t  sbq[$];
    ex_t   exState;
    bit    lastStall;
    int    cycle;
    int    checks;
    int    errors;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit writes(input logic en, input logic [4:0] a, input logic [4:0] r);
        return en && (a != 5'd0) && (a == r);
    endfunction

    // Value of register r seen by the EX instruction this cycle.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] held,
                                            input stim_t x);
`ifdef FORWARD_EN
        if (writes(x.memRegWr, x.memWAddr, r)) return x.memResult;
        if (writes(x.wbRegWr, x.wbWAddr, r)) return x.wbResult;
`endif
        return held;
    endfunction

    // ID must hold when it reads a register not yet available to it.
    function automatic bit mustStall(input ex_t e, input stim_t x);
        bit h;
        if (x.flush || !x.valid) return 1'b0;
        h = e.present && e.loads && (e.rd != 5'd0) && (e.rd == x.rs || e.rd == x.rt);
`ifndef FORWARD_EN
        h = h || writes(e.present && e.writes, e.rd, x.rs)
              || writes(e.present && e.writes, e.rd, x.rt)
              || writes(x.memRegWr, x.memWAddr, x.rs)
              || writes(x.memRegWr, x.memWAddr, x.rt);
`endif
        return h;
    endfunction

    function automatic exp_t predict(input ex_t e, input stim_t x);
        exp_t r;
        logic [31:0] rtNow;
        rtNow   = operand(e.rt, e.rtVal, x);
        r.cyc   = 0;
        r.valid = e.present;
        r.regWr = e.present && e.writes;
        r.memRd = e.present && e.loads;
        r.stall = mustStall(e, x);
        r.care  = e.present || e.cleared;
        r.rd    = e.rd;
        r.fun   = e.fun;
        r.sign  = e.sign;
        r.a     = e.useShamt ? {27'd0, e.shamt} : operand(e.rs, e.rsVal, x);
        r.b     = e.useImm ? e.imm : rtNow;
        r.store = rtNow;
        return r;
    endfunction

    function automatic ex_t advance(input ex_t e, input stim_t x);
        ex_t n;
        n = '{default: '0};
        if (x.reset) begin
            n.cleared = 1'b1;
            return n;
        end
        n.present  = x.valid && !x.flush && !mustStall(e, x);
        n.writes   = x.regWr;
        n.loads    = x.memRd;
        n.rd       = x.rd;
        n.rs       = x.rs;
        n.rt       = x.rt;
        n.shamt    = x.shamt;
        n.fun      = x.fun;
        n.sign     = x.sign;
        n.useImm   = x.aluSrc;
        n.useShamt = x.shiftSrc;
        n.imm      = x.imm;
        n.rsVal    = writes(x.wbRegWr, x.wbWAddr, x.rs) ? x.wbResult : x.rsData;
        n.rtVal    = writes(x.wbRegWr, x.wbWAddr, x.rt) ? x.wbResult : x.rtData;
        return n;
    endfunction

    task automatic apply(input stim_t x);
        rst            = x.reset;
        bus.iValid     = x.valid;
        bus.iFlush     = x.flush;
        bus.iRsData    = x.rsData;
        bus.iRtData    = x.rtData;
        bus.iRs        = x.rs;
        bus.iRt        = x.rt;
        bus.iRd        = x.rd;
        bus.iImm       = x.imm;
        bus.iShamt     = x.shamt;
        bus.iALUFun    = x.fun;
        bus.iSign      = x.sign;
        bus.iALUSrc    = x.aluSrc;
        bus.iShiftSrc  = x.shiftSrc;
        bus.iRegWr     = x.regWr;
        bus.iMemRd     = x.memRd;
        bus.iMemRegWr  = x.memRegWr;
        bus.iMemWAddr  = x.memWAddr;
        bus.iMemResult = x.memResult;
        bus.iWbRegWr   = x.wbRegWr;
        bus.iWbWAddr   = x.wbWAddr;
        bus.iWbResult  = x.wbResult;
    endtask

    // One clock of stimulus: drive, record expectation, advance the model.
    task automatic step(input stim_t x);
        exp_t r;
        @(posedge clk);
        #1;
        apply(x);
        r = predict(exState, x);
        r.cyc = cycle;
        sbq.push_back(r);
        lastStall = r.stall;
        exState = advance(exState, x);
        cycle++;
    endtask

    function automatic stim_t randStim(input stim_t prev, input bit hold);
        stim_t s;
        if (hold) begin
            s = prev;
        end else begin
            s.valid    = ($urandom_range(0, 9) < 8);
            s.rsData   = $urandom();
            s.rtData   = $urandom();
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.rd       = 5'($urandom_range(0, 3));
            s.imm      = $urandom();
            s.shamt    = 5'($urandom_range(0, 31));
            s.fun      = 6'($urandom_range(0, 63));
            s.sign     = 1'($urandom_range(0, 1));
            s.aluSrc   = ($urandom_range(0, 9) < 3);
            s.shiftSrc = ($urandom_range(0, 9) < 2);
            s.regWr    = ($urandom_range(0, 9) < 7);
            s.memRd    = ($urandom_range(0, 9) < 3);
        end
        s.reset     = ($urandom_range(0, 63) == 0);
        s.flush     = ($urandom_range(0, 9) == 0);
        s.memRegWr  = 1'($urandom_range(0, 1));
        s.memWAddr  = 5'($urandom_range(0, 3));
        s.memResult = $urandom();
        s.wbRegWr   = 1'($urandom_range(0, 1));
        s.wbWAddr   = 5'($urandom_range(0, 3));
        s.wbResult  = $urandom();
        return s;
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t r;
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            chk("oValid",   r.cyc, 32'(bus.oValid),   32'(r.valid));
            chk("oRegWr",   r.cyc, 32'(bus.oRegWr),   32'(r.regWr));
            chk("oMemRd",   r.cyc, 32'(bus.oMemRd),   32'(r.memRd));
            chk("oStallID", r.cyc, 32'(bus.oStallID), 32'(r.stall));
            if (r.care) begin
                chk("oRd",        r.cyc, 32'(bus.oRd),      32'(r.rd));
                chk("oALUFun",    r.cyc, 32'(bus.oALUFun),  32'(r.fun));
                chk("oSign",      r.cyc, 32'(bus.oSign),    32'(r.sign));
                chk("oA",         r.cyc, bus.oA,            r.a);
                chk("oB",         r.cyc, bus.oB,            r.b);
                chk("oStoreData", r.cyc, bus.oStoreData,    r.store);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, lw, prev;
        checks  = 0;
        errors  = 0;
        cycle   = 0;
        exState = '{default: '0};
        s = idle();
        s.reset = 1'b1;
        apply(s);
        @(posedge clk);
        exState.cleared = 1'b1;
        step(s);
        @(negedge clk);
        chk("reset_oA", cycle, bus.oA, 32'd0);
        chk("reset_oStallID", cycle, 32'(bus.oStallID), 32'd0);

        lw = idle();
        lw.valid = 1'b1; lw.memRd = 1'b1; lw.regWr = 1'b1; lw.rd = 5'd5;

        // Load-use: stall one cycle, then a bubble in EX.
        step(idle());
        step(lw);
        s = idle();
        s.valid = 1'b1; s.rs = 5'd1; s.rt = 5'd5; s.rd = 5'd6; s.regWr = 1'b1;
        step(s);
        @(negedge clk);
        chk("loaduse_stall", cycle, 32'(bus.oStallID), 32'd1);
        s.memRegWr = 1'b1; s.memWAddr = 5'd5; s.memResult = 32'h0000_0055;
        step(s);
        @(negedge clk);
        chk("loaduse_bubble", cycle, 32'(bus.oValid), 32'd0);
        s.memRegWr = 1'b0;
        s.wbRegWr = 1'b1; s.wbWAddr = 5'd5; s.wbResult = 32'h0000_0055;
        step(s);
        step(idle());
        step(idle());

        // Flush overrides the load-use stall.
        step(lw);
        s = idle();
        s.valid = 1'b1; s.rt = 5'd5; s.regWr = 1'b1; s.rd = 5'd2; s.flush = 1'b1;
        step(s);
        @(negedge clk);
        chk("flush_nostall", cycle, 32'(bus.oStallID), 32'd0);
        step(idle());
        @(negedge clk);
        chk("flush_oValid", cycle, 32'(bus.oValid), 32'd0);
        chk("flush_oRegWr", cycle, 32'(bus.oRegWr), 32'd0);

        // MEM beats WB on r7; r0 is never forwarded.
        step(idle());
        s = idle();
        s.valid = 1'b1; s.rs = 5'd7; s.rsData = 32'h1111_1111; s.regWr = 1'b1; s.rd = 5'd9;
        step(s);
        s = idle();
        s.memRegWr = 1'b1; s.memWAddr = 5'd7; s.memResult = 32'hAAAA_0000;
        s.wbRegWr = 1'b1; s.wbWAddr = 5'd7; s.wbResult = 32'h5555_FFFF;
        step(s);
        @(negedge clk);
`ifdef FORWARD_EN
        chk("mem_beats_wb", cycle, bus.oA, 32'hAAAA_0000);
`else
        chk("no_fwd_oA", cycle, bus.oA, 32'h1111_1111);
`endif
        s = idle();
        s.valid = 1'b1; s.rs = 5'd0; s.rsData = 32'h0; s.regWr = 1'b1; s.rd = 5'd9;
        step(s);
        s = idle();
        s.memRegWr = 1'b1; s.memWAddr = 5'd0; s.memResult = 32'hAAAA_0000;
        s.wbRegWr = 1'b1; s.wbWAddr = 5'd0; s.wbResult = 32'h5555_FFFF;
        step(s);
        @(negedge clk);
        chk("r0_not_forwarded", cycle, bus.oA, 32'h0);

        // Reset while stalled drops the EX load and the stall.
        step(idle());
        step(lw);
        s = idle();
        s.valid = 1'b1; s.rt = 5'd5; s.regWr = 1'b1; s.rd = 5'd2; s.reset = 1'b1;
        step(s);
        @(negedge clk);
        chk("prereset_stall", cycle, 32'(bus.oStallID), 32'd1);
        s.reset = 1'b0;
        step(s);
        @(negedge clk);
        chk("rststall_oStallID", cycle, 32'(bus.oStallID), 32'd0);
        chk("rststall_oValid", cycle, 32'(bus.oValid), 32'd0);
        chk("rststall_oMemRd", cycle, 32'(bus.oMemRd), 32'd0);
        chk("rststall_oRd", cycle, 32'(bus.oRd), 32'd0);
        chk("rststall_oB", cycle, bus.oB, 32'd0);
        chk("rststall_oStoreData", cycle, bus.oStoreData, 32'd0);

        // add r3 in EX, dependent instruction in ID.
        step(idle());
        s = idle();
        s.valid = 1'b1; s.regWr = 1'b1; s.rd = 5'd3; s.fun = 6'h20;
        step(s);
        s = idle();
        s.valid = 1'b1; s.rs = 5'd3; s.regWr = 1'b1; s.rd = 5'd4;
        step(s);
        @(negedge clk);
`ifdef FORWARD_EN
        chk("add_nostall", cycle, 32'(bus.oStallID), 32'd0);
        s = idle();
        s.memRegWr = 1'b1; s.memWAddr = 5'd3; s.memResult = 32'h0000_0010;
        step(s);
        @(negedge clk);
        chk("add_fwd_oA", cycle, bus.oA, 32'h0000_0010);
`else
        chk("add_stall_ex", cycle, 32'(bus.oStallID), 32'd1);
        s.memRegWr = 1'b1; s.memWAddr = 5'd3; s.memResult = 32'h0000_0010;
        step(s);
        @(negedge clk);
        chk("add_stall_mem", cycle, 32'(bus.oStallID), 32'd1);
        s.memRegWr = 1'b0;
        s.wbRegWr = 1'b1; s.wbWAddr = 5'd3; s.wbResult = 32'h0000_0010;
        step(s);
        @(negedge clk);
        chk("add_stall_wb", cycle, 32'(bus.oStallID), 32'd0);
        step(idle());
        @(negedge clk);
        chk("add_wt_oA", cycle, bus.oA, 32'h0000_0010);
        chk("add_wt_oValid", cycle, 32'(bus.oValid), 32'd1);
`endif

        // Randomized traffic; ID re-presents its instruction while stalled.
        prev = idle();
        for (int i = 0; i < 3000; i++) begin
            s = randStim(prev, lastStall && !prev.reset);
            step(s);
            prev = s;
        end

        step(idle());
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
